sort_job_arbiter: RTL
=====================

Name: sort_job_arbiter

Overview:
Shares one systolic odd-even sort engine (max-finder for softmax/nonlinear units) between NUM_REQ requesters. Round-robin arbitration accepts one DATA_NUM-element vector at a time over valid/ready. The block registers the vector, pulses the sorter enable, waits for sort_finish, then returns the maximum tagged with the requester id over a valid/ready response channel.

Parameters:
FIX_POINT_WIDTH, 16, element width in bits
DATA_NUM, 8, elements per vector (even, >=2)
NUM_REQ, 2, number of requesters (2..4)
ID_W, 2, response id width; must satisfy 2^ID_W >= NUM_REQ
TIMEOUT_CYCLES, 255, RUN-state cycle limit (used only with SORT_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester vector valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_data  in  NUM_REQ*DATA_NUM*FIX_POINT_WIDTH  requester k occupies slice k
sort_en  out  1  single-cycle start pulse to sorter
sort_in  out  DATA_NUM*FIX_POINT_WIDTH  registered vector to sorter
sort_max  in  FIX_POINT_WIDTH  sorter maximum output
sort_finish  in  1  sorter done
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_max  out  FIX_POINT_WIDTH  captured maximum
rsp_id  out  ID_W  index of the granted requester
rsp_err  out  1  timeout flag (constant 0 without macro)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; rr_ptr=NUM_REQ-1; req_ready=0, sort_en=0, sort_in=0, rsp_valid=0, rsp_max=0, rsp_id=0, rsp_err=0, busy=0; cycle counter=0.
- FSM states: IDLE, START, RUN, RESP.
- IDLE: req_ready is combinational. The bit for the first valid requester, searching from rr_ptr+1 modulo NUM_REQ, is high. On the handshake edge: sort_in<=req_data slice, grant_id<=k, rr_ptr<=k, next state START. No valid request: remain in IDLE.
- START: sort_en=1 for exactly one cycle; counter<=0; next state RUN.
- RUN: sort_in held stable. counter increments each cycle. On sort_finish=1: rsp_max<=sort_max, rsp_id<=grant_id, rsp_err<=0, rsp_valid<=1, next state RESP.
- RESP: rsp_valid, rsp_max, rsp_id and rsp_err are held until rsp_ready=1. On the handshake edge: rsp_valid<=0, next state IDLE.
- req_ready is 0 in every state except IDLE. This gives one job in flight and a minimum one-cycle bubble between jobs.
- Latency: accept at edge T. sort_en is high in cycle T+1. If sort_finish is seen in cycle F, rsp_valid is high from F+1.
- sort_finish outside RUN is ignored. sort_finish in the same cycle that sort_en is high is also ignored, because the block is still in START.
- Fairness: a requester that was just granted has lowest priority at the next arbitration. No requester waits longer than NUM_REQ-1 jobs.
- req_data is sampled only at the handshake edge. Later changes do not affect the job in flight.
- Async reset mid-job: everything returns to reset values and the in-flight job is dropped without a response.

Optional Feature:
SORT_TIMEOUT_EN
- Defined: in RUN, if the counter reaches TIMEOUT_CYCLES without sort_finish, go to RESP with rsp_err=1, rsp_max=0, rsp_id=grant_id. A sort_finish arriving later is ignored. The counter saturates.
- Undefined: no counter limit; RUN waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single job: DATA_NUM=8, requester 0 sends {3,-7,12,5,0,9,1,2} and the sorter model returns 12 after 28 cycles. Required: sort_en is a one-cycle pulse at T+1; rsp_valid rises at F+1 with rsp_max=12, rsp_id=0, rsp_err=0.
- Round-robin: both requesters hold valid for 4 jobs. Required: grant order 0,1,0,1, and req_ready is never two-hot.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp_max and rsp_id stay stable; req_ready stays 0 while requester 1 waits; requester 1 is granted the cycle after the RESP handshake.
- Spurious finish: pulse sort_finish while in IDLE and again during the START cycle. Required: no state change and no response.
- Reset mid-RUN: drop rst low for 1 cycle. Required: all outputs return to 0 immediately and the next grant goes to requester 0.
- With SORT_TIMEOUT_EN and TIMEOUT_CYCLES=20: sorter never finishes. Required: rsp_valid with rsp_err=1 and rsp_max=0 about 21 cycles after sort_en; a late sort_finish is ignored.

Source files
------------

// File: rtl/sort_job_arbiter.sv
// Round-robin front end that shares one odd-even sort engine between NUM_REQ requesters.
// Optional macro SORT_TIMEOUT_EN bounds the RUN state and reports a timeout through rsp_err.
module sort_job_arbiter #(
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DATA_NUM        = 8,
    parameter int NUM_REQ         = 2,
    parameter int ID_W            = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic [NUM_REQ*DATA_NUM*FIX_POINT_WIDTH-1:0] req_data,
    output logic                                        sort_en,
    output logic [DATA_NUM*FIX_POINT_WIDTH-1:0]         sort_in,
    input  logic [FIX_POINT_WIDTH-1:0]                  sort_max,
    input  logic                                        sort_finish,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [FIX_POINT_WIDTH-1:0]                  rsp_max,
    output logic [ID_W-1:0]                             rsp_id,
    output logic                                        rsp_err,
    output logic                                        busy
);

    localparam int VEC_W = DATA_NUM * FIX_POINT_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    pick_id;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   cnt_next;
    logic               found;
    logic               accept;
    int                 cand;

`ifdef SORT_TIMEOUT_EN
    logic               err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Grant search starts one past the last winner; ready is also gated by reset
    // so nothing looks accepted while the block is held in reset.
    always_comb begin
        req_ready = '0;
        pick_id   = '0;
        found     = 1'b0;
        cand      = 0;
        if (state == IDLE && rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(rr_ptr) + 1 + i;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!found && ((req_valid >> cand) & NUM_REQ'(1)) != '0) begin
                    found     = 1'b1;
                    req_ready = NUM_REQ'(1) << cand;
                    pick_id   = ID_W'(cand);
                end
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign cnt_next = (counter == CNT_W'(TIMEOUT_CYCLES)) ? counter : counter + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            grant_id  <= '0;
            sort_en   <= 1'b0;
            sort_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_max   <= '0;
            rsp_id    <= '0;
            counter   <= '0;
`ifdef SORT_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            sort_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sort_in  <= req_data[int'(pick_id)*VEC_W +: VEC_W];
                        grant_id <= pick_id;
                        rr_ptr   <= pick_id;
                        sort_en  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    counter <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    counter <= cnt_next;
                    if (sort_finish) begin
                        rsp_max   <= sort_max;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef SORT_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        // Sorter never answered: report an error result instead of hanging.
                        rsp_max   <= '0;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
